adc_spi_sampler: RTL

ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

---
 rtl/adc_spi_sampler_if.sv | 19 +
 rtl/adc_spi_sampler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/adc_spi_sampler_if.sv
// SPI link between the sampler and an external 12-bit ADC.
// master: cs_n/sclk out, sdo in; slave: the ADC side.
interface adc_spi_sampler_if;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_sdo;

    modport master (
        output adc_cs_n,
        output adc_sclk,
        input  adc_sdo
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sclk,
        output adc_sdo
    );
endinterface

// File: rtl/adc_spi_sampler.sv
// Periodic SPI ADC sampler: one 16-bit frame per sample tick.
// Ports: clk, reset (async low), enable, spi (master), adc_data_in, sample_valid, frame_error, overrun.
module adc_spi_sampler #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned CS_SETUP      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    adc_spi_sampler_if.master spi,
    output logic [15:0]       adc_data_in,
    output logic              sample_valid,
    output logic              frame_error,
    output logic              overrun
);

    localparam int TW = $clog2(SAMPLE_PERIOD + 1);
    localparam int DW = $clog2(CLK_DIV + 1);

    localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
    localparam logic [3:0]    S_LAST = 4'(CS_SETUP - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            tick;
    logic [DW-1:0]   div_cnt;
    logic [4:0]      half_cnt;
    logic [3:0]      setup_cnt;
    logic [15:0]     shift_q;

    assign tick = enable && (timer == T_LAST);

    // Disabling the sampler restarts the period from scratch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (!enable || timer == T_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            spi.adc_cs_n <= 1'b1;
            spi.adc_sclk <= 1'b1;
            adc_data_in  <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
            shift_q      <= '0;
            div_cnt      <= '0;
            half_cnt     <= '0;
            setup_cnt    <= '0;
        end else begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            // A tick seen outside IDLE is dropped and flagged.
            overrun      <= tick && (state != IDLE);

            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state        <= SETUP;
                        spi.adc_cs_n <= 1'b0;
                        setup_cnt    <= '0;
                    end
                end
                SETUP: begin
                    if (setup_cnt == S_LAST) begin
                        state        <= SHIFT;
                        spi.adc_sclk <= 1'b0;
                        div_cnt      <= '0;
                        half_cnt     <= '0;
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == D_LAST) begin
                        div_cnt <= '0;
                        // Capture on the edge that raises sclk.
                        if (!spi.adc_sclk) begin
                            shift_q <= {shift_q[14:0], spi.adc_sdo};
                        end
                        if (half_cnt == 5'd31) begin
                            state        <= HOLD;
                            spi.adc_cs_n <= 1'b1;
                            spi.adc_sclk <= 1'b1;
                        end else begin
                            half_cnt     <= half_cnt + 1'b1;
                            spi.adc_sclk <= ~spi.adc_sclk;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    state        <= DONE;
                    adc_data_in  <= {4'b0, shift_q[11:0]};
                    sample_valid <= 1'b1;
                    frame_error  <= |shift_q[15:12];
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
